// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory
// and fills the IF/ID register, handling stall, redirect, halt and faults.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 301
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pc4;
  logic [31:0] inst_nx, pc4_nx, count_nx;
  logic        valid_nx, fault_nx;
  logic [32:0] last_byte;
  logic        bad_fetch;

  assign inst_addr = pc;
  assign pc4       = pc + 32'd4;

  // 33-bit sum so a PC near the top of the address space cannot wrap into range
  assign last_byte = {1'b0, pc} + 33'd3;
  assign bad_fetch = (pc[1:0] != 2'b00) ||
                     (last_byte > 33'(MEM_BYTES - 1));

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = ifid_inst;
    pc4_nx   = ifid_pc_plus4;
    valid_nx = ifid_valid;
    fault_nx = fetch_fault;
    count_nx = fetch_count;
    unique case (state)
      S_BOOT: begin
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (bad_fetch) begin
          fault_nx = 1'b1;
          valid_nx = 1'b0;
          state_nx = S_HALT;
        end else if (halt) begin
          valid_nx = 1'b0;
          inst_nx  = 32'd0;
          state_nx = S_HALT;
        end else if (branch_taken) begin
          pc_nx    = branch_target;
          valid_nx = 1'b0;
          inst_nx  = 32'd0;
        end else if (jump) begin
          pc_nx    = jump_target;
          valid_nx = 1'b0;
          inst_nx  = 32'd0;
        end else if (!stall) begin
          pc_nx    = pc4;
          inst_nx  = inst_in;
          pc4_nx   = pc4;
          valid_nx = 1'b1;
          count_nx = fetch_count + 32'd1;
        end
      end
      S_HALT: begin
        valid_nx = 1'b0;
      end
      default: begin
        state_nx = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      ifid_inst     <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
      fetch_fault   <= 1'b0;
      fetch_count   <= 32'd0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      ifid_inst     <= inst_nx;
      ifid_pc_plus4 <= pc4_nx;
      ifid_valid    <= valid_nx;
      fetch_fault   <= fault_nx;
      fetch_count   <= count_nx;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues expected IF/ID state,
// a negedge monitor pops and compares it.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        halt = 1'b0;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [5:0]  m;
    logic        v;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        f;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  localparam logic [5:0] M_ALL = 6'h3F;
  localparam logic [5:0] M_NOI = 6'h3B;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign inst_in = w(inst_addr);

  if_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .halt(halt),
    .inst_addr(inst_addr),
    .inst_in(inst_in),
    .ifid_inst(ifid_inst),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s got %h want %h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) cmp(e.name, "valid", {31'd0, ifid_valid}, {31'd0, e.v});
      if (e.m[1]) cmp(e.name, "pc4", ifid_pc_plus4, e.pc4);
      if (e.m[2]) cmp(e.name, "inst", ifid_inst, e.inst);
      if (e.m[3]) cmp(e.name, "addr", inst_addr, e.addr);
      if (e.m[4]) cmp(e.name, "fault", {31'd0, fetch_fault}, {31'd0, e.f});
      if (e.m[5]) cmp(e.name, "count", fetch_count, e.cnt);
    end
  end

  task automatic drive(input logic r, input logic st,
                       input logic bt, input logic [31:0] btg,
                       input logic j, input logic [31:0] jt,
                       input logic h);
    @(negedge clk);
    rst_n = r;
    stall = st;
    branch_taken = bt;
    branch_target = btg;
    jump = j;
    jump_target = jt;
    halt = h;
  endtask

  task automatic cyc(input string nm, input logic [5:0] m,
                     input logic v, input logic [31:0] pc4,
                     input logic [31:0] inst, input logic [31:0] addr,
                     input logic f, input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    e.name = nm; e.m = m; e.v = v; e.pc4 = pc4;
    e.inst = inst; e.addr = addr; e.f = f; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic run(input string nm, input logic [5:0] m,
                     input logic v, input logic [31:0] pc4,
                     input logic [31:0] inst, input logic [31:0] addr,
                     input logic f, input logic [31:0] cnt);
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc(nm, m, v, pc4, inst, addr, f, cnt);
  endtask

  task automatic do_reset(input string nm);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc(nm, M_ALL, 0, 0, 0, 0, 0, 0);
    end
    run({nm, "_boot"}, M_ALL, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset("rst");

    run("f0", M_ALL, 1, 4, w(0), 4, 0, 1);
    run("f1", M_ALL, 1, 8, w(4), 8, 0, 2);
    run("f2", M_ALL, 1, 12, w(8), 12, 0, 3);

    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      cyc("stall", M_ALL, 1, 12, w(8), 12, 0, 3);
    end

    run("f3", M_ALL, 1, 16, w(12), 16, 0, 4);
    run("f4", M_ALL, 1, 20, w(16), 20, 0, 5);

    drive(1, 1, 1, 40, 0, 0, 0);
    cyc("br_stall", M_ALL, 0, 20, 0, 40, 0, 5);
    run("br_fetch", M_ALL, 1, 44, w(40), 44, 0, 6);

    drive(1, 0, 1, 60, 1, 100, 0);
    cyc("br_over_j", M_ALL, 0, 44, 0, 60, 0, 6);
    run("f60", M_ALL, 1, 64, w(60), 64, 0, 7);

    drive(1, 1, 0, 0, 1, 296, 0);
    cyc("j_stall", M_ALL, 0, 64, 0, 296, 0, 7);
    run("f296", M_ALL, 1, 300, w(296), 300, 0, 8);
    run("flt300", M_NOI, 0, 300, 0, 300, 1, 8);

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, i[0], 32'd0, 1, 32'd0, 0);
      cyc("flt_hold", M_NOI, 0, 300, 0, 300, 1, 8);
    end

    do_reset("rst2");

    drive(1, 0, 1, 6, 0, 0, 0);
    cyc("br6", M_ALL, 0, 0, 0, 6, 0, 0);
    run("mis6", M_NOI, 0, 0, 0, 6, 1, 0);

    do_reset("rst3");
    run("g0", M_ALL, 1, 4, w(0), 4, 0, 1);
    run("g1", M_ALL, 1, 8, w(4), 8, 0, 2);

    drive(1, 0, 1, 40, 0, 0, 1);
    cyc("halt_br", M_NOI, 0, 8, 0, 8, 0, 2);
    for (int i = 0; i < 4; i++) begin
      run("halted", M_NOI, 0, 8, 0, 8, 0, 2);
    end

    do_reset("rst4");
    run("h0", M_ALL, 1, 4, w(0), 4, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
